pio_debounced_input: RTL and testbench



---
 rtl/pio_debounced_input.sv | 114 +++++++++++
 tb/tb_pio_debounced_input.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_debounced_input.sv
// Avalon-MM input port for buttons and switches: synchroniser, per-bit
// debounce, configurable edge capture, interrupt mask and level IRQ.
module pio_debounced_input #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_s1;
    logic [WIDTH-1:0] sync_s2;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_d;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] clr_bits;
    logic [31:0]      rd_next;
    logic             unused_inputs;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
        end else begin
            sync_s1 <= in_port;
            sync_s2 <= sync_s1;
        end
    end

    // Each bit owns its counter so one bouncing pin never delays another.
    for (genvar i = 0; i < WIDTH; i++) begin : g_deb
        logic [CW-1:0] cnt;
        logic          deb_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt   <= '0;
                deb_q <= 1'b0;
            end else if (sync_s2[i] == deb_q) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                deb_q <= sync_s2[i];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign deb[i] = deb_q;
    end

    always_comb begin
        edge_det = '0;
        if (EDGE_TYPE == 0) begin
            edge_det = deb & ~deb_d;
        end else if (EDGE_TYPE == 1) begin
            edge_det = ~deb & deb_d;
        end else begin
            edge_det = deb ^ deb_d;
        end
    end

    always_comb begin
        clr_bits = '0;
        if (write && address == 2'd3) begin
            clr_bits = writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        rd_next = '0;
        unique case (address)
            2'd0: rd_next[WIDTH-1:0] = deb;
            2'd1: rd_next            = '0;
            2'd2: rd_next[WIDTH-1:0] = irq_mask;
            2'd3: rd_next[WIDTH-1:0] = edge_cap;
        endcase
    end

    // A fresh edge outranks a simultaneous write-1-to-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_d    <= '0;
            edge_cap <= '0;
            irq_mask <= '0;
            readdata <= '0;
        end else begin
            deb_d    <= deb;
            edge_cap <= (edge_cap & ~clr_bits) | edge_det;
            readdata <= rd_next;
            if (write && address == 2'd2) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    assign irq = |(edge_cap & irq_mask);

    assign unused_inputs = ^{read, writedata};

endmodule

// File: tb/tb_pio_debounced_input.sv
// Bench for pio_debounced_input: directed vectors and corner sequences,
// then random traffic against a window-based reference model.
module tb_pio_debounced_input;

    localparam int W   = 4;
    localparam int DEB = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    address = '0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [31:0]   writedata = '0;
    logic [W-1:0]  in_port = '0;
    logic [31:0]   rd0, rd1, rd2;
    logic          irq0, irq1, irq2;

    int n_cmp = 0;
    int n_bad = 0;

    pio_debounced_input #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB), .EDGE_TYPE(0)) dut0 (
        .clk(clk), .reset(reset), .address(address), .read(read),
        .write(write), .writedata(writedata), .in_port(in_port),
        .readdata(rd0), .irq(irq0)
    );

    pio_debounced_input #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB), .EDGE_TYPE(1)) dut1 (
        .clk(clk), .reset(reset), .address(address), .read(read),
        .write(write), .writedata(writedata), .in_port(in_port),
        .readdata(rd1), .irq(irq1)
    );

    pio_debounced_input #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB), .EDGE_TYPE(2)) dut2 (
        .clk(clk), .reset(reset), .address(address), .read(read),
        .write(write), .writedata(writedata), .in_port(in_port),
        .readdata(rd2), .irq(irq2)
    );

    always #5 clk = ~clk;

    // Reference model: a bit flips once its last DEB synchronised samples
    // all disagree with the current debounced value.
    logic [W-1:0]   m_s1, m_s2, m_deb, m_debd, m_mask;
    logic [W-1:0]   m_ec [3];
    logic [31:0]    m_rd [3];
    logic [DEB-1:0] m_hist [W];

    task automatic model_step();
        logic [W-1:0] edge_v;
        logic [W-1:0] clr;
        logic [W-1:0] old_deb;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0; m_debd = '0; m_mask = '0;
            for (int i = 0; i < W; i++) m_hist[i] = '0;
            for (int k = 0; k < 3; k++) begin
                m_ec[k] = '0;
                m_rd[k] = '0;
            end
        end else begin
            clr = (write && address == 2'd3) ? writedata[W-1:0] : '0;
            for (int k = 0; k < 3; k++) begin
                case (address)
                    2'd0:    m_rd[k] = 32'(m_deb);
                    2'd2:    m_rd[k] = 32'(m_mask);
                    2'd3:    m_rd[k] = 32'(m_ec[k]);
                    default: m_rd[k] = 32'h0;
                endcase
                if (k == 0)      edge_v = m_deb & ~m_debd;
                else if (k == 1) edge_v = ~m_deb & m_debd;
                else             edge_v = m_deb ^ m_debd;
                m_ec[k] = (m_ec[k] & ~clr) | edge_v;
            end
            if (write && address == 2'd2) m_mask = writedata[W-1:0];
            old_deb = m_deb;
            m_debd  = old_deb;
            for (int i = 0; i < W; i++) begin
                m_hist[i] = {m_hist[i][DEB-2:0], m_s2[i]};
                if (m_hist[i] == {DEB{~old_deb[i]}}) m_deb[i] = ~old_deb[i];
            end
            m_s2 = m_s1;
            m_s1 = in_port;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] a, input logic w, input logic [31:0] d);
        address   = a;
        write     = w;
        writedata = d;
        read      = ~w;
        cycle();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]   addr;
        logic         wr;
        logic [31:0]  wd;
        logic [W-1:0] pin;
        logic [31:0]  exp_rd;
        logic         exp_irq;
    } vec_t;

    vec_t tbl [24];

    task automatic glitch(input int len, input logic exp_seen, input logic [31:0] exp_ec);
        logic seen;
        seen = 1'b0;
        in_port = 4'hD;
        for (int c = 0; c < len; c++) begin
            drive(2'd0, 1'b0, 32'h0);
            seen |= rd0[3];
        end
        in_port = 4'h5;
        for (int c = 0; c < 12; c++) begin
            drive(2'd0, 1'b0, 32'h0);
            seen |= rd0[3];
        end
        check($sformatf("glitch%0d_data", len), 32'(seen), 32'(exp_seen));
        drive(2'd3, 1'b0, 32'h0);
        check($sformatf("glitch%0d_ec", len), rd0, exp_ec);
        check($sformatf("glitch%0d_irq", len), 32'(irq0), 32'(exp_ec != 0));
        drive(2'd3, 1'b1, 32'hF);
    endtask

    initial begin
        logic early;

        tbl[0]  = '{2'd0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0};
        tbl[1]  = '{2'd1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0};
        tbl[2]  = '{2'd2, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0};
        tbl[3]  = '{2'd3, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0};
        for (int r = 4; r < 10; r++) tbl[r] = '{2'd0, 1'b0, 32'h0, 4'h5, 32'h0, 1'b0};
        tbl[10] = '{2'd0, 1'b0, 32'h0, 4'h5, 32'h5, 1'b0};
        tbl[11] = '{2'd3, 1'b0, 32'h0, 4'h5, 32'h5, 1'b0};
        tbl[12] = '{2'd2, 1'b1, 32'h1, 4'h5, 32'h0, 1'b1};
        tbl[13] = '{2'd2, 1'b0, 32'h0, 4'h5, 32'h1, 1'b1};
        tbl[14] = '{2'd3, 1'b1, 32'h1, 4'h5, 32'h5, 1'b0};
        tbl[15] = '{2'd3, 1'b0, 32'h0, 4'h5, 32'h4, 1'b0};
        tbl[16] = '{2'd3, 1'b1, 32'h4, 4'h5, 32'h4, 1'b0};
        tbl[17] = '{2'd3, 1'b0, 32'h0, 4'h5, 32'h0, 1'b0};
        tbl[18] = '{2'd2, 1'b1, 32'hFFFF_FFFF, 4'h5, 32'h1, 1'b0};
        tbl[19] = '{2'd2, 1'b0, 32'h0, 4'h5, 32'hF, 1'b0};
        tbl[20] = '{2'd0, 1'b1, 32'hFFFF_FFFF, 4'h5, 32'h5, 1'b0};
        tbl[21] = '{2'd1, 1'b1, 32'hFFFF_FFFF, 4'h5, 32'h0, 1'b0};
        tbl[22] = '{2'd0, 1'b0, 32'h0, 4'h5, 32'h5, 1'b0};
        tbl[23] = '{2'd3, 1'b0, 32'h0, 4'h5, 32'h0, 1'b0};

        reset = 1'b1;
        repeat (3) cycle();
        check("reset_rd", rd0, 32'h0);
        check("reset_irq", 32'(irq0), 32'h0);
        reset = 1'b0;

        for (int r = 0; r < 24; r++) begin
            in_port = tbl[r].pin;
            drive(tbl[r].addr, tbl[r].wr, tbl[r].wd);
            check($sformatf("vec%0d_rd", r), rd0, tbl[r].exp_rd);
            check($sformatf("vec%0d_irq", r), 32'(irq0), 32'(tbl[r].exp_irq));
        end

        glitch(3, 1'b0, 32'h0);
        glitch(4, 1'b1, 32'h8);

        // Falling edge lands on the same clock as a clearing write.
        drive(2'd3, 1'b1, 32'hF);
        in_port = 4'h4;
        for (int c = 0; c < 6; c++) drive(2'd3, 1'b0, 32'h0);
        drive(2'd3, 1'b1, 32'h1);
        check("fall_pre", rd1, 32'h0);
        drive(2'd3, 1'b0, 32'h0);
        check("set_wins", rd1, 32'h1);

        drive(2'd3, 1'b1, 32'hF);
        in_port = 4'h5;
        for (int c = 0; c < 8; c++) drive(2'd3, 1'b0, 32'h0);
        drive(2'd3, 1'b0, 32'h0);
        check("any_rise", rd2, 32'h1);
        drive(2'd3, 1'b1, 32'h1);
        in_port = 4'h4;
        drive(2'd3, 1'b0, 32'h0);
        check("any_clr", rd2, 32'h0);
        for (int c = 0; c < 8; c++) drive(2'd3, 1'b0, 32'h0);
        check("any_fall", rd2, 32'h1);

        // Reset lands two cycles into a debounce count.
        in_port = 4'h0;
        for (int c = 0; c < 10; c++) drive(2'd0, 1'b0, 32'h0);
        drive(2'd3, 1'b1, 32'hF);
        in_port = 4'h1;
        for (int c = 0; c < 4; c++) drive(2'd3, 1'b0, 32'h0);
        reset = 1'b1;
        for (int c = 0; c < 2; c++) drive(2'd3, 1'b0, 32'h0);
        reset = 1'b0;
        early = 1'b0;
        for (int c = 0; c < 7; c++) begin
            drive(2'd3, 1'b0, 32'h0);
            early |= (rd0 != 32'h0);
        end
        check("rst_no_early", 32'(early), 32'h0);
        drive(2'd3, 1'b0, 32'h0);
        check("rst_edge", rd0, 32'h1);
        check("rst_irq", 32'(irq0), 32'h0);
        drive(2'd0, 1'b1, 32'hFFFF_FFFF);
        check("ro_data", rd0, 32'h1);
        drive(2'd1, 1'b1, 32'hFFFF_FFFF);
        check("ro_rsvd", rd0, 32'h0);
        drive(2'd3, 1'b0, 32'h0);
        check("ro_ec", rd0, 32'h1);
        drive(2'd2, 1'b0, 32'h0);
        check("ro_mask", rd0, 32'h0);

        reset = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(5, 0) == 0) in_port[$urandom_range(W-1, 0)] ^= 1'b1;
            reset     = ($urandom_range(999, 0) == 0);
            address   = 2'($urandom);
            write     = ($urandom_range(7, 0) == 0);
            read      = ~write;
            writedata = $urandom;
            cycle();
            check("rnd_rd0", rd0, m_rd[0]);
            check("rnd_rd1", rd1, m_rd[1]);
            check("rnd_rd2", rd2, m_rd[2]);
            check("rnd_irq0", 32'(irq0), 32'(|(m_ec[0] & m_mask)));
            check("rnd_irq1", 32'(irq1), 32'(|(m_ec[1] & m_mask)));
            check("rnd_irq2", 32'(irq2), 32'(|(m_ec[2] & m_mask)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
